ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//   Two-requester, burst-locking round-robin arbiter for the single-port packet RAM.
//   Requester A is the PIT datapath; requester B is the SPI/MCU readback path.
//   Each burst (one packet) gets exclusive RAM ownership.
//   Tags the synchronous 1-cycle RAM read data back to whichever requester issued the read.
// PARAMETERS
//   ADDR_W     10  RAM row (entry) address width
//   BYTE_W     10  byte-offset-within-entry width
//   DATA_W      8  RAM data width
//   MAX_BURST  64  max accepted beats per grant before forced release (>=1)
// PORTS
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   req_a      in   1       A requests a RAM beat this cycle
//   we_a       in   1       A beat is a write (1) or read (0)
//   last_a     in   1       A beat is the final beat of its burst
//   addr_a     in   ADDR_W  A entry address
//   byte_a     in   BYTE_W  A byte offset
//   wdata_a    in   DATA_W  A write data
//   req_b/we_b/last_b/addr_b/byte_b/wdata_b  in  same widths as A  requester B equivalents
//   gnt_a      out  1       A owns the RAM (registered)
//   gnt_b      out  1       B owns the RAM (registered)
//   rvalid_a   out  1       rdata holds A's read result (1-cycle pulse)
//   rvalid_b   out  1       rdata holds B's read result (1-cycle pulse)
//   rdata      out  DATA_W  read data, direct from ram_q
//   ram_addr   out  ADDR_W  to RAM addr
//   ram_byte   out  BYTE_W  to RAM byte
//   ram_data   out  DATA_W  to RAM write data
//   ram_we     out  1       to RAM write enable
//   ram_q      in   DATA_W  RAM read data, valid 1 cycle after the read beat
// BEHAVIOUR
//   Reset values
//   - State IDLE; gnt_a, gnt_b, rvalid_a, rvalid_b = 0.
//   - Beat counter = 0; priority pointer = A.
//   - ram_we = 0 throughout reset.
//   Beat acceptance
//   - A beat is accepted in a cycle where req_x && gnt_x.
//   - Requester inputs are sampled only in accepted cycles.
//   RAM drive
//   - ram_addr/ram_byte/ram_data mux the current owner's inputs combinationally.
//   - ram_we = req_x & gnt_x & we_x for the owner; 0 otherwise (including IDLE).
//   - In IDLE the mux selects A's inputs.
//   FSM states: IDLE, OWN_A, OWN_B. gnt_a = (state==OWN_A); gnt_b = (state==OWN_B).
//   - IDLE: if exactly one request is pending, grant it next cycle. If both are pending,
//     grant the pointer side. No beat is accepted in IDLE; grant latency is 1 cycle.
//   - OWN_x release triggers:
//     - accepted beat with last_x = 1;
//     - accepted beat that brings the beat counter to MAX_BURST;
//     - req_x = 0 while granted (abandon).
//   - On release, the pointer moves to the other side. The next state is OWN_other if
//     req_other = 1 in the release cycle, otherwise IDLE. No idle bubble when the other
//     side is waiting.
//   - No release trigger: stay in OWN_x; the beat counter increments on each accepted beat.
//   - The beat counter clears on every state change. Its width is clog2(MAX_BURST+1) and
//     it never wraps.
//   Read return
//   - An accepted read beat (we_x = 0) sets rvalid_x = 1 on the following cycle only.
//   - rdata = ram_q in that cycle.
//   - The rvalid tag is registered at the accept, so a read accepted on the release beat
//     still returns to its issuer even though ownership has moved.
//   - Back-to-back reads give rvalid high on consecutive cycles with rdata pipelined.
//   Simultaneous events
//   - A requester that releases with last and re-requests in the same cycle does not get
//     a back-to-back grant if the other side is requesting.
//   - Otherwise it re-arbitrates via IDLE, costing 1 cycle.
//   Reset mid-burst: grant and rvalid drop asynchronously, and any in-flight read return is
//   discarded. The requester must restart its burst.
//   A write and a read never occur in the same cycle: there is a single owner and single port.
// TESTING
//   1. Only req_a: 4 writes (we_a=1, addr 5, byte 0..3, data 0x10..0x13, last on byte 3)
//      -> gnt_a rises 1 cycle after req_a; ram_we high 4 cycles; state IDLE after.
//   2. req_a and req_b both asserted from reset
//      -> A granted first; when A's burst ends with last, gnt_b rises the next cycle
//      with no IDLE gap.
//   3. B reads addr 5, bytes 0..3 back-to-back
//      -> rvalid_b high for 4 consecutive cycles, each 1 cycle after its accept;
//      rdata = 0x10, 0x11, 0x12, 0x13; rvalid_a stays 0.
//   4. MAX_BURST=4, A streams 10 beats with no last while B requests
//      -> A released after beat 4, B granted, then A regains the grant after B's last.
//   5. Assert rst during the 2nd beat of an A read burst
//      -> gnt_a, rvalid_a, ram_we go 0 immediately; after reset, state IDLE, pointer = A.
//   6. A drops req mid-burst after 2 beats while B is idle
//      -> gnt_a falls the next cycle; state IDLE; counter cleared.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-requester round-robin arbiter for the single-port packet RAM. A is the
//   PIT datapath, B is the SPI/MCU readback path. Ownership is held for a whole
//   burst (until last, MAX_BURST beats, or the owner drops its request), and the
//   synchronous 1-cycle RAM read data is tagged back to the issuing requester.
// Ports
//   clk, rst                       clock, async active-high reset
//   req/we/last/addr/byte/wdata_x  requester x beat (x = a, b)
//   gnt_a, gnt_b                   current RAM owner (from state register)
//   rvalid_a, rvalid_b             rdata carries x's read result this cycle
//   rdata                          read data, straight from ram_q
//   ram_addr/byte/data/we, ram_q   RAM port
module ram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int BYTE_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic              last_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [BYTE_W-1:0] byte_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic              last_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [BYTE_W-1:0] byte_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_byte,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state;
  logic             ptr_b;   // 1: B wins the next tie
  logic [CNT_W-1:0] cnt;     // accepted beats in the current grant
  logic             acc_a, acc_b, at_max, rel_a, rel_b;

  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);

  assign acc_a  = gnt_a & req_a;
  assign acc_b  = gnt_b & req_b;
  // The beat being accepted now is the MAX_BURST-th one.
  assign at_max = (cnt == CNT_W'(MAX_BURST - 1));
  // Dropping req while owning is an abandon; otherwise the beat is accepted
  // and may end the grant through last or the burst limit.
  assign rel_a  = gnt_a & (~req_a | last_a | at_max);
  assign rel_b  = gnt_b & (~req_b | last_b | at_max);

  // A's inputs are selected in IDLE as well as OWN_A.
  assign ram_addr = gnt_b ? addr_b  : addr_a;
  assign ram_byte = gnt_b ? byte_b  : byte_a;
  assign ram_data = gnt_b ? wdata_b : wdata_a;
  assign ram_we   = (acc_a & we_a) | (acc_b & we_b);
  assign rdata    = ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr_b    <= 1'b0;
      cnt      <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      // Tag follows the issuer, not the owner of the next cycle.
      rvalid_a <= acc_a & ~we_a;
      rvalid_b <= acc_b & ~we_b;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_a && req_b) state <= ptr_b ? OWN_B : OWN_A;
          else if (req_a)     state <= OWN_A;
          else if (req_b)     state <= OWN_B;
        end
        OWN_A: begin
          if (rel_a) begin
            ptr_b <= 1'b1;
            cnt   <= '0;
            state <= req_b ? OWN_B : IDLE;
          end else if (acc_a) begin
            cnt <= cnt + 1'b1;
          end
        end
        OWN_B: begin
          if (rel_b) begin
            ptr_b <= 1'b0;
            cnt   <= '0;
            state <= req_a ? OWN_A : IDLE;
          end else if (acc_b) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with MAX_BURST=4 and a small behavioural RAM.
// Stimulus posts expected values into queues; a single monitor process owns
// all comparisons and the error/check counters.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 10, BYTE_W = 10, DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic req_a, we_a, last_a, req_b, we_b, last_b;
  logic [ADDR_W-1:0] addr_a, addr_b, ram_addr;
  logic [BYTE_W-1:0] byte_a, byte_b, ram_byte;
  logic [DATA_W-1:0] wdata_a, wdata_b, rdata, ram_data, ram_q;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .last_a(last_a), .addr_a(addr_a), .byte_a(byte_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .last_b(last_b), .addr_b(addr_b), .byte_b(byte_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata(rdata),
    .ram_addr(ram_addr), .ram_byte(ram_byte), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Synchronous single-port RAM, 1-cycle read latency.
  logic [DATA_W-1:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[{ram_addr[4:0], ram_byte[4:0]}] <= ram_data;
    ram_q <= mem[{ram_addr[4:0], ram_byte[4:0]}];
  end

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t              chkq[$];
  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chkq.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: read returns against the expected queues, then posted checks.
  initial begin
    chk_t c;
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rvalid_a) begin
        n_chk++;
        if (qa.size() == 0) begin
          n_err++; $display("FAIL rdata_a: unexpected rvalid_a, rdata=%0h", rdata);
        end else begin
          e = qa.pop_front();
          if (rdata !== e) begin n_err++; $display("FAIL rdata_a: got %0h expected %0h", rdata, e); end
        end
      end
      if (rvalid_b) begin
        n_chk++;
        if (qb.size() == 0) begin
          n_err++; $display("FAIL rdata_b: unexpected rvalid_b, rdata=%0h", rdata);
        end else begin
          e = qb.pop_front();
          if (rdata !== e) begin n_err++; $display("FAIL rdata_b: got %0h expected %0h", rdata, e); end
        end
      end
      while (chkq.size() > 0) begin
        c = chkq.pop_front();
        n_chk++;
        if (c.act !== c.exp) begin
          n_err++;
          $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_a = 0; we_a = 0; last_a = 0; addr_a = '0; byte_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; last_b = 0; addr_b = '0; byte_b = '0; wdata_b = '0;
    repeat (2) tick();

    // 1: A writes addr 5 bytes 0..3; reset must hold everything low.
    req_a = 1; we_a = 1; addr_a = 5; byte_a = 0; wdata_a = 8'h10;
    smp();
    chk("rst_gnt_a", gnt_a, 0); chk("rst_gnt_b", gnt_b, 0);
    chk("rst_ram_we", ram_we, 0); chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
    tick(); rst = 0;
    smp();
    chk("t1_idle_gnt_a", gnt_a, 0); chk("t1_idle_we", ram_we, 0); chk("t1_idle_addr", ram_addr, 5);
    tick();
    for (int b = 0; b < 4; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h10 + b[7:0]; last_a = (b == 3);
      smp();
      chk("t1_gnt_a", gnt_a, 1); chk("t1_we", ram_we, 1);
      chk("t1_byte", ram_byte, b); chk("t1_data", ram_data, 32'h10 + b);
      tick();
    end
    req_a = 0; last_a = 0;
    smp(); chk("t1_rel_gnt_a", gnt_a, 0); chk("t1_rel_we", ram_we, 0);

    // 2+3: both request from reset; A writes 2 beats, B then reads addr 5.
    rst = 1;
    req_a = 1; we_a = 1; addr_a = 7; byte_a = 0; wdata_a = 8'h20; last_a = 0;
    req_b = 1; we_b = 0; addr_b = 5; byte_b = 0; last_b = 0;
    tick(); rst = 0;
    smp(); chk("t2_idle_gnt_a", gnt_a, 0); chk("t2_idle_gnt_b", gnt_b, 0);
    tick();
    for (int b = 0; b < 2; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h20 + b[7:0]; last_a = (b == 1);
      smp(); chk("t2_gnt_a", gnt_a, 1); chk("t2_gnt_b", gnt_b, 0);
      tick();
    end
    req_a = 0; last_a = 0;
    for (int b = 0; b < 4; b++) begin
      byte_b = b[BYTE_W-1:0]; last_b = (b == 3);
      smp();
      chk("t3_gnt_b", gnt_b, 1); chk("t3_gnt_a", gnt_a, 0); chk("t3_we", ram_we, 0);
      chk("t3_rvalid_a", rvalid_a, 0); chk("t3_rvalid_b", rvalid_b, (b != 0));
      qb.push_back(8'h10 + b[7:0]);
      tick();
    end
    req_b = 0; last_b = 0;
    smp(); chk("t3_rvalid_b_end", rvalid_b, 1); chk("t3_rel_gnt_b", gnt_b, 0);
    tick();

    // 4: A streams with no last while B waits; burst limit forces release.
    req_a = 1; we_a = 1; addr_a = 9; byte_a = 0; wdata_a = 8'h30; last_a = 0;
    req_b = 1; we_b = 0; addr_b = 9; byte_b = 0; last_b = 0;
    smp(); chk("t4_idle_gnt_a", gnt_a, 0); tick();
    for (int b = 0; b < 4; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h30 + b[7:0];
      smp(); chk("t4_gnt_a", gnt_a, 1); chk("t4_byte", ram_byte, b); tick();
    end
    byte_a = 4; wdata_a = 8'h34;
    for (int k = 0; k < 2; k++) begin
      byte_b = k[BYTE_W-1:0]; last_b = (k == 1);
      smp(); chk("t4_gnt_b", gnt_b, 1); chk("t4_gnt_a_off", gnt_a, 0);
      qb.push_back(8'h30 + k[7:0]);
      tick();
    end
    req_b = 0; last_b = 0;
    for (int b = 4; b < 8; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h30 + b[7:0];
      smp(); chk("t4_regain_gnt_a", gnt_a, 1); tick();
    end
    byte_a = 8; wdata_a = 8'h38;
    smp(); chk("t4_max_idle_gnt_a", gnt_a, 0); chk("t4_max_idle_we", ram_we, 0); tick();
    for (int b = 8; b < 10; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h30 + b[7:0];
      smp(); chk("t4_tail_gnt_a", gnt_a, 1); tick();
    end
    req_a = 0;
    smp(); chk("t4_abandon_gnt_a", gnt_a, 1); chk("t4_abandon_we", ram_we, 0); tick();
    smp(); chk("t4_abandon_rel", gnt_a, 0);
    req_b = 1; byte_b = 4; last_b = 0;
    tick();
    smp(); chk("t4_rb_gnt_b", gnt_b, 1); qb.push_back(8'h34); tick();
    byte_b = 9; last_b = 1;
    smp(); chk("t4_rb_gnt_b2", gnt_b, 1); qb.push_back(8'h39); tick();
    req_b = 0; last_b = 0;

    // 5: reset during the 2nd beat of an A read burst.
    req_a = 1; we_a = 0; addr_a = 5; byte_a = 0; last_a = 0;
    smp(); tick();
    smp(); chk("t5_gnt_a", gnt_a, 1); qa.push_back(8'h10); tick();
    byte_a = 1;
    smp(); chk("t5_rvalid_a", rvalid_a, 1); chk("t5_gnt_a2", gnt_a, 1);
    #1 rst = 1;
    #1;
    chk("t5_rst_gnt_a", gnt_a, 0); chk("t5_rst_rvalid_a", rvalid_a, 0); chk("t5_rst_we", ram_we, 0);
    req_a = 1; we_a = 1; addr_a = 7; byte_a = 5; wdata_a = 8'h55; last_a = 1;
    req_b = 1; we_b = 0; addr_b = 7; byte_b = 5; last_b = 1;
    tick(); rst = 0;
    smp(); chk("t5_post_gnt_a", gnt_a, 0); chk("t5_post_gnt_b", gnt_b, 0); tick();
    smp(); chk("t5_ptr_gnt_a", gnt_a, 1); chk("t5_ptr_gnt_b", gnt_b, 0); chk("t5_ptr_we", ram_we, 1); tick();
    req_a = 0; last_a = 0;
    smp(); chk("t5_gnt_b", gnt_b, 1); qb.push_back(8'h55); tick();
    req_b = 0; last_b = 0;
    smp(); chk("t5_rvalid_b", rvalid_b, 1); tick();

    // 6: A abandons after 2 beats; counter must restart for the next grant.
    req_a = 1; we_a = 1; addr_a = 8; byte_a = 0; wdata_a = 8'h60; last_a = 0;
    smp(); chk("t6_idle_gnt_a", gnt_a, 0); tick();
    for (int b = 0; b < 2; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h60 + b[7:0];
      smp(); chk("t6_gnt_a", gnt_a, 1); tick();
    end
    req_a = 0;
    smp(); chk("t6_drop_gnt_a", gnt_a, 1); chk("t6_drop_we", ram_we, 0); tick();
    smp(); chk("t6_rel_gnt_a", gnt_a, 0);
    req_a = 1; byte_a = 2; wdata_a = 8'h62;
    tick();
    for (int b = 2; b < 6; b++) begin
      byte_a = b[BYTE_W-1:0]; wdata_a = 8'h60 + b[7:0];
      smp(); chk("t6_cnt_gnt_a", gnt_a, 1); tick();
    end
    byte_a = 6; wdata_a = 8'h66;
    smp(); chk("t6_cnt_rel", gnt_a, 0);
    req_a = 0;
    tick();
    req_b = 1; we_b = 0; addr_b = 8; byte_b = 1; last_b = 0;
    tick();
    smp(); chk("t6_rb_gnt_b", gnt_b, 1); qb.push_back(8'h61); tick();
    byte_b = 5; last_b = 1;
    smp(); qb.push_back(8'h65); tick();
    req_b = 0; last_b = 0;

    repeat (3) tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    repeat (2) smp();
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop in case the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, got stalled expected done");
    $fatal(1, "timeout");
  end
endmodule
